// File: rtl/mips_alu_seq.sv
// Clocked MIPS execute-stage ALU with valid/ready handshakes, iterative
// multiply/divide into HI/LO, branch-taken and illegal-instruction flags.
module mips_alu_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [WIDTH-1:0] rs_content,
   input  logic [WIDTH-1:0] rt_content,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             branch_taken,
   output logic             illegal,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_result, r_hi, r_lo;
   logic                 r_branch, r_illegal;
   logic [WIDTH-1:0]     r_accHi, r_accLo, r_opB;
   logic [SHAMT_W-1:0]   r_cnt;
   logic                 r_negQ, r_negR;

   logic [5:0]           w_opcode, w_funct;
   logic [15:0]          w_imm;
   logic [SHAMT_W-1:0]   w_shamt, w_vshamt;
   logic [WIDTH-1:0]     w_simm, w_zimm, w_absRs, w_absRt;
   logic [WIDTH-1:0]     w_res;
   logic                 w_bt, w_ill, w_isMul, w_isDiv, w_signedOp;
   logic [WIDTH:0]       w_mulSum, w_divShift, w_divDiff;
   logic                 w_divGe;
   logic [WIDTH-1:0]     w_mulHiNext, w_mulLoNext, w_remNext, w_quoNext;
   logic [2*WIDTH-1:0]   w_prod, w_prodFinal;
   logic [WIDTH-1:0]     w_quoFinal, w_remFinal;
   logic                 w_unusedBits;

   assign w_opcode = instruction[31:26];
   assign w_funct  = instruction[5:0];
   assign w_imm    = instruction[15:0];
   assign w_shamt  = SHAMT_W'(instruction[10:6]);
   assign w_vshamt = rs_content[SHAMT_W-1:0];
   assign w_simm   = WIDTH'($signed(w_imm));
   assign w_zimm   = WIDTH'(w_imm);
   assign w_absRs  = (w_signedOp && rs_content[WIDTH-1]) ? -rs_content : rs_content;
   assign w_absRt  = (w_signedOp && rt_content[WIDTH-1]) ? -rt_content : rt_content;

   // Instruction decode and the single-cycle result, evaluated on the accept cycle.
   always_comb begin
      w_res      = '0;
      w_bt       = 1'b0;
      w_ill      = 1'b0;
      w_isMul    = 1'b0;
      w_isDiv    = 1'b0;
      w_signedOp = 1'b0;
      if (w_opcode == 6'd0) begin
         case (w_funct)
            6'd0:  w_res = rt_content << w_shamt;
            6'd2:  w_res = rt_content >> w_shamt;
            6'd3:  w_res = $unsigned($signed(rt_content) >>> w_shamt);
            6'd4:  w_res = rt_content << w_vshamt;
            6'd6:  w_res = rt_content >> w_vshamt;
            6'd7:  w_res = $unsigned($signed(rt_content) >>> w_vshamt);
            6'd8:  w_res = rs_content;
            6'd16: w_res = r_hi;
            6'd18: w_res = r_lo;
            6'd24: begin w_isMul = 1'b1; w_signedOp = 1'b1; end
            6'd25: w_isMul = 1'b1;
            6'd26: begin w_isDiv = 1'b1; w_signedOp = 1'b1; end
            6'd27: w_isDiv = 1'b1;
            6'd32, 6'd33: w_res = rs_content + rt_content;
            6'd34, 6'd35: w_res = rs_content - rt_content;
            6'd36: w_res = rs_content & rt_content;
            6'd37: w_res = rs_content | rt_content;
            6'd38: w_res = rs_content ^ rt_content;
            6'd39: w_res = ~(rs_content | rt_content);
            6'd42: w_res = {{(WIDTH-1){1'b0}}, $signed(rs_content) < $signed(rt_content)};
            6'd43: w_res = {{(WIDTH-1){1'b0}}, rs_content < rt_content};
            default: w_ill = 1'b1;
         endcase
      end else begin
         case (w_opcode)
            6'd2, 6'd3: w_res = '0;
            6'd4: begin w_res = rs_content - rt_content; w_bt = (rs_content == rt_content); end
            6'd5: begin w_res = rs_content - rt_content; w_bt = (rs_content != rt_content); end
            6'd8, 6'd9: w_res = rs_content + w_simm;
            6'd10: w_res = {{(WIDTH-1){1'b0}}, $signed(rs_content) < $signed(w_simm)};
            6'd11: w_res = {{(WIDTH-1){1'b0}}, rs_content < w_simm};
            6'd12: w_res = rs_content & w_zimm;
            6'd13: w_res = rs_content | w_zimm;
            6'd14: w_res = rs_content ^ w_zimm;
            6'd15: w_res = WIDTH'({w_imm, 16'h0000});
            6'd32, 6'd33, 6'd35, 6'd40, 6'd41, 6'd43: w_res = rs_content + w_simm;
            default: w_ill = 1'b1;
         endcase
      end
   end

   // Shift-add multiply on magnitudes; the sign is reapplied to the full product.
   assign w_mulSum    = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : '0);
   assign w_mulHiNext = w_mulSum[WIDTH:1];
   assign w_mulLoNext = {w_mulSum[0], r_accLo[WIDTH-1:1]};
   assign w_prod      = {w_mulHiNext, w_mulLoNext};
   assign w_prodFinal = r_negQ ? -w_prod : w_prod;

   assign w_divShift  = {r_accHi, r_accLo[WIDTH-1]};
   assign w_divGe     = (w_divShift >= {1'b0, r_opB});
   assign w_divDiff   = w_divShift - {1'b0, r_opB};
   assign w_remNext   = w_divGe ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0];
   assign w_quoNext   = {r_accLo[WIDTH-2:0], w_divGe};
   assign w_quoFinal  = r_negQ ? -w_quoNext : w_quoNext;
   assign w_remFinal  = r_negR ? -w_remNext : w_remNext;

   assign w_unusedBits = ^{instruction[25:16], w_divDiff[WIDTH]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_result  <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_branch  <= 1'b0;
         r_illegal <= 1'b0;
         r_accHi   <= '0;
         r_accLo   <= '0;
         r_opB     <= '0;
         r_cnt     <= '0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_result  <= w_res;
               r_branch  <= w_bt;
               r_illegal <= w_ill;
               r_negQ    <= w_signedOp && (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
               r_negR    <= w_signedOp && rs_content[WIDTH-1];
               r_cnt     <= SHAMT_W'(WIDTH-1);
               r_accHi   <= '0;
               if (w_isMul) begin
                  r_accLo <= w_absRt;
                  r_opB   <= w_absRs;
                  r_state <= MUL;
               end else if (w_isDiv && rt_content == '0) begin
                  r_hi     <= rs_content;
                  r_lo     <= '1;
                  r_result <= '1;
                  r_state  <= DONE;
               end else if (w_isDiv) begin
                  r_accLo <= w_absRs;
                  r_opB   <= w_absRt;
                  r_state <= DIV;
               end else begin
                  r_state <= DONE;
               end
            end
            MUL: begin
               r_accHi <= w_mulHiNext;
               r_accLo <= w_mulLoNext;
               r_cnt   <= r_cnt - SHAMT_W'(1);
               if (r_cnt == '0) begin
                  r_hi     <= w_prodFinal[2*WIDTH-1:WIDTH];
                  r_lo     <= w_prodFinal[WIDTH-1:0];
                  r_result <= w_prodFinal[WIDTH-1:0];
                  r_state  <= DONE;
               end
            end
            DIV: begin
               r_accHi <= w_remNext;
               r_accLo <= w_quoNext;
               r_cnt   <= r_cnt - SHAMT_W'(1);
               if (r_cnt == '0) begin
                  r_hi     <= w_remFinal;
                  r_lo     <= w_quoFinal;
                  r_result <= w_quoFinal;
                  r_state  <= DONE;
               end
            end
            DONE: if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state == IDLE);
   assign out_valid    = (r_state == DONE);
   assign result       = r_result;
   assign branch_taken = r_branch;
   assign illegal      = r_illegal;
   assign hi           = r_hi;
   assign lo           = r_lo;

endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
Parametrised, clocked successor to the combinational MIPS ALU, with a valid/ready handshake on input and output. Single-cycle R/I-type operations return in one cycle. It adds iterative multiply/divide (mult, multu, div, divu), HI/LO registers with mfhi/mflo, variable shifts, a branch-taken flag and an illegal-op flag. It sits in the execute stage between register-file read and memory/writeback.

Parameters:
WIDTH, 32, datapath width in bits; legal range 16..64.
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  instruction and operands are valid
in_ready  out  1  block can accept; high only in IDLE
instruction  in  32  MIPS instruction word
rs_content  in  WIDTH  rs operand
rt_content  in  WIDTH  rt operand
out_valid  out  1  result, branch_taken and illegal are valid; held until out_ready
out_ready  in  1  consumer accepts the output
result  out  WIDTH  ALU result or load/store address
branch_taken  out  1  beq/bne condition true
illegal  out  1  opcode/funct not supported
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0; result, hi and lo all zero; branch_taken=0, illegal=0.
- Operand capture: an accept happens on a clk edge with in_valid&&in_ready; instruction and operands are registered on that edge. Inputs are ignored when in_ready=0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accept of a single-cycle op goes to DONE.
  - IDLE: accept of mult/multu (funct 24/25) goes to MUL.
  - IDLE: accept of div/divu (funct 26/27) goes to DIV.
  - MUL/DIV: run exactly WIDTH iterations (counter WIDTH-1 down to 0), then go to DONE.
  - DONE: out_valid=1; go to IDLE on out_ready. Outputs stay stable while out_ready=0.
- Latency, accept at edge T:
  - single-cycle op: out_valid at T+1.
  - mul/div: out_valid at T+WIDTH+1.
  - divide by zero: out_valid at T+1.
  - Max throughput is one op per 2 cycles (in_ready is low in DONE).
- R-type (opcode 0), decoded by funct:
  - add, addu, sub, subu: modulo 2^WIDTH; no overflow trap.
  - and, or, xor; nor=~(rs|rt).
  - sll, srl: logical; sra: arithmetic; shift amount = shamt[SHAMT_W-1:0].
  - sllv/srlv/srav (4/6/7): shift amount = rs[SHAMT_W-1:0].
  - slt: signed compare; sltu: unsigned compare.
  - jr: result=rs.
  - mfhi (16) / mflo (18): result=hi / lo.
- I-type:
  - addi/addiu/slti: sign-extended imm16. sltiu: sign-extended imm16, unsigned compare.
  - andi/ori/xori: zero-extended imm16.
  - lui: result=imm16<<16, truncated to WIDTH.
  - lb/lh/lw/sb/sh/sw (32/33/35/40/41/43): result=rs+sext(imm16).
  - beq/bne: branch_taken set on the condition; result=rs-rt.
- j/jal (2/3): result=0, branch_taken=0, not illegal.
- Any other opcode/funct: illegal=1, result=0. hi/lo unchanged.
- mult: signed 2*WIDTH product; multu: unsigned. On entry to DONE: hi=upper half, lo=lower half; result=lo.
- div/divu: restoring divider, one quotient bit per cycle. lo=quotient, hi=remainder, result=lo. Signed div truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: no iteration; hi=rs, lo=all ones, result=lo.
- hi/lo change only on completion of mult/div. Single-cycle ops never modify them.
- Reset mid-MUL/DIV: the operation is aborted. hi/lo return to zero and no out_valid is produced.

Test Plan:
- add: rs=5, rt=0xFFFFFFFE, funct 32, accept at T -> out_valid at T+1, result=3; out_ready=1 -> in_ready=1 at T+2.
- sra/srl: rt=0x80000000, shamt=4 -> sra result=0xF8000000; srl result=0x08000000. nor with rs=rt=0 -> result=0xFFFFFFFF.
- mult: rs=-3, rt=5 -> out_valid exactly at T+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then mfhi -> result=0xFFFFFFFF.
- div: rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu: 100/7 -> lo=14, hi=2. div by zero: rs=9 -> out_valid at T+1, hi=9, lo=0xFFFFFFFF.
- Backpressure: out_ready held 0 for 5 cycles after bne with rs!=rt -> out_valid, result and branch_taken=1 stable; in_ready=0; new in_valid ignored.
- Reset at T+10 of a multu, then illegal opcode 0x3F -> state IDLE, hi=lo=0, no out_valid; subsequent op returns illegal=1, result=0.
